// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a toggle req/ack handshake. A word accepted on
// the valid/ready port is held on tx_data, tx_req toggles one cycle later, and the
// block waits for the destination's ack toggle (synchronized here) to match tx_req.
//
// state    | meaning
// IDLE     | ready for a new word (s_ready high)
// SETUP    | word registered on tx_data; tx_req toggles at the next edge
// WAIT_ACK | request launched; waiting for synchronized ack to equal tx_req
module cdc_handshake_tx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             rx_ack,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   accept;
  logic                   launch;
  logic                   ack_seen;

  // Ack synchronizer: rx_ack feeds the first flop directly, no logic in front of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], rx_ack};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the handshake strobes used by the datapath.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    launch    = 1'b0;
    ack_seen  = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        busy      = 1'b1;
        launch    = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (ack_s == tx_req) begin
          ack_seen  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload, request toggle and done pulse; tx_data/tx_req only move on accept/launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data <= '0;
      tx_req  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= ack_seen;
      if (accept) tx_data <= s_data;
      if (launch) tx_req  <= ~tx_req;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: two instances, one with a same-clock destination model
// (SYNC_STAGES=2) and one with a slower, unrelated destination clock (SYNC_STAGES=3).
`timescale 1ns/100ps
module tb_cdc_handshake_tx;
  localparam int W = 32;

  logic clk = 1'b0;
  logic dclk = 1'b0;
  logic reset;

  logic         s_valid, s_ready, tx_req, rx_ack, busy, done;
  logic [W-1:0] s_data, tx_data;
  logic         s_valid2, s_ready2, tx_req2, rx_ack2, busy2, done2;
  logic [W-1:0] s_data2, tx_data2;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic exp_req;

  always #5 clk = ~clk;
  initial begin
    #1.3;
    forever #13.5 dclk = ~dclk;
  end

  cdc_handshake_tx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx_data(tx_data), .tx_req(tx_req), .rx_ack(rx_ack), .busy(busy), .done(done)
  );

  cdc_handshake_tx #(.WIDTH(W), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .tx_data(tx_data2), .tx_req(tx_req2), .rx_ack(rx_ack2), .busy(busy2), .done(done2)
  );

  // Destination model A: same clock, 2-flop req sync, ack returned 3 cycles after capture.
  logic         da_s1, da_s2, da_prev, da_pend;
  int           da_cnt;
  logic [W-1:0] rx_words [0:15];
  int           rx_cnt = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      da_s1 <= 1'b0; da_s2 <= 1'b0; da_prev <= 1'b0; da_pend <= 1'b0; da_cnt <= 0; rx_ack <= 1'b0;
    end else begin
      da_s1 <= tx_req; da_s2 <= da_s1; da_prev <= da_s2;
      if (da_s2 != da_prev) begin
        rx_words[rx_cnt % 16] <= tx_data;
        rx_cnt  <= rx_cnt + 1;
        da_cnt  <= 3;
        da_pend <= 1'b1;
      end else if (da_pend) begin
        if (da_cnt == 1) begin
          rx_ack  <= da_prev;
          da_pend <= 1'b0;
        end
        da_cnt <= da_cnt - 1;
      end
    end
  end

  // Destination model B: slow unrelated clock, same behaviour.
  logic         db_s1, db_s2, db_prev, db_pend;
  int           db_cnt;
  logic [W-1:0] rx2_words [0:127];
  int           rx2_cnt = 0;
  always @(posedge dclk or posedge reset) begin
    if (reset) begin
      db_s1 <= 1'b0; db_s2 <= 1'b0; db_prev <= 1'b0; db_pend <= 1'b0; db_cnt <= 0; rx_ack2 <= 1'b0;
    end else begin
      db_s1 <= tx_req2; db_s2 <= db_s1; db_prev <= db_s2;
      if (db_s2 != db_prev) begin
        rx2_words[rx2_cnt % 128] <= tx_data2;
        rx2_cnt <= rx2_cnt + 1;
        db_cnt  <= 3;
        db_pend <= 1'b1;
      end else if (db_pend) begin
        if (db_cnt == 1) begin
          rx_ack2 <= db_prev;
          db_pend <= 1'b0;
        end
        db_cnt <= db_cnt - 1;
      end
    end
  end

  // Done pulse counters.
  int done_cnt  = 0;
  int done2_cnt = 0;
  always @(posedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  // clk edges since rx_ack2 last changed (0 at the first edge that sees the change).
  logic ack2_last;
  int   lat2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ack2_last <= 1'b0; lat2 <= 0;
    end else if (rx_ack2 != ack2_last) begin
      ack2_last <= rx_ack2; lat2 <= 0;
    end else begin
      lat2 <= lat2 + 1;
    end
  end

  property p_stable;
    @(posedge clk) disable iff (reset) (busy && $past(busy)) |-> $stable(tx_data);
  endproperty
  a_stable: assert property (p_stable)
    else $error("FAIL tx_data_stable_assert: tx_data changed to %h while busy", tx_data);

  logic [W-1:0] sent2 [0:99];

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_valid2 = 1'b0; s_data2 = '0; exp_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b expected 1", s_ready); else pass_cnt++;
    chk_cnt++; if (tx_req !== 1'b0) $display("FAIL rst_tx_req: got %b expected 0", tx_req); else pass_cnt++;
    chk_cnt++; if (tx_data !== '0) $display("FAIL rst_tx_data: got %h expected 0", tx_data); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({s_ready, busy, done, tx_req} !== 4'b1000 || tx_data !== '0)
        $display("FAIL idle_hold cycle %0d: got rdy=%b busy=%b done=%b req=%b data=%h expected 1 0 0 0 0",
                 i, s_ready, busy, done, tx_req, tx_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int n, rx0, dn0;
    rx0 = rx_cnt; dn0 = done_cnt;
    s_valid = 1'b1; s_data = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_data = '0;
    chk_cnt++; if (tx_data !== 32'hDEADBEEF) $display("FAIL single_tx_data: got %h expected deadbeef", tx_data); else pass_cnt++;
    chk_cnt++; if (tx_req !== exp_req) $display("FAIL single_req_setup: got %b expected %b", tx_req, exp_req); else pass_cnt++;
    chk_cnt++; if ({s_ready, busy} !== 2'b01) $display("FAIL single_setup_flags: got rdy=%b busy=%b expected 0 1", s_ready, busy); else pass_cnt++;
    @(negedge clk);
    exp_req = ~exp_req;
    chk_cnt++; if (tx_req !== exp_req) $display("FAIL single_req_launch: got %b expected %b", tx_req, exp_req); else pass_cnt++;
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk_cnt++; if (done !== 1'b1) $display("FAIL single_done_timeout: got done=%b expected 1", done); else pass_cnt++;
    chk_cnt++; if (s_ready !== 1'b1) $display("FAIL single_ready_with_done: got %b expected 1", s_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0) $display("FAIL single_done_width: got %b expected 0", done); else pass_cnt++;
    chk_cnt++; if (rx_cnt - rx0 !== 1) $display("FAIL single_rx_count: got %0d expected 1", rx_cnt - rx0); else pass_cnt++;
    chk_cnt++; if (rx_words[rx0 % 16] !== 32'hDEADBEEF) $display("FAIL single_rx_word: got %h expected deadbeef", rx_words[rx0 % 16]); else pass_cnt++;
    chk_cnt++; if (done_cnt - dn0 !== 1) $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - dn0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, rx0, dn0;
    rx0 = rx_cnt; dn0 = done_cnt;
    s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n = 0;
      while (s_ready !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      chk_cnt++; if (s_ready !== 1'b1) $display("FAIL b2b_ready_timeout word %0d: got %b expected 1", i, s_ready); else pass_cnt++;
      s_data = W'(i);
      @(posedge clk);
      @(negedge clk);
      exp_req = ~exp_req;
      chk_cnt++; if (tx_data !== W'(i)) $display("FAIL b2b_tx_data word %0d: got %h expected %h", i, tx_data, W'(i)); else pass_cnt++;
    end
    s_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk_cnt++; if (done !== 1'b1) $display("FAIL b2b_last_done_timeout: got %b expected 1", done); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (rx_cnt - rx0 !== 4) $display("FAIL b2b_rx_count: got %0d expected 4", rx_cnt - rx0); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (rx_words[(rx0 + i) % 16] !== W'(i + 1))
        $display("FAIL b2b_rx_order idx %0d: got %h expected %h", i, rx_words[(rx0 + i) % 16], W'(i + 1));
      else pass_cnt++;
    end
    chk_cnt++; if (tx_req !== exp_req) $display("FAIL b2b_req_parity: got %b expected %b", tx_req, exp_req); else pass_cnt++;
    chk_cnt++; if (done_cnt - dn0 !== 4) $display("FAIL b2b_done_pulses: got %0d expected 4", done_cnt - dn0); else pass_cnt++;
  endtask

  task automatic test_data_stable();
    int n, rx0;
    rx0 = rx_cnt;
    s_valid = 1'b1; s_data = 32'hA5A50001;
    @(posedge clk);
    @(negedge clk);
    exp_req = ~exp_req;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      chk_cnt++; if (tx_data !== 32'hA5A50001) $display("FAIL stable_tx_data cycle %0d: got %h expected a5a50001", n, tx_data); else pass_cnt++;
      s_data  = $urandom;
      s_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    chk_cnt++; if (done !== 1'b1) $display("FAIL stable_done: got %b expected 1", done); else pass_cnt++;
    chk_cnt++; if (tx_data !== 32'hA5A50001) $display("FAIL stable_after_done: got %h expected a5a50001", tx_data); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (tx_req !== exp_req) $display("FAIL stable_req_parity: got %b expected %b", tx_req, exp_req); else pass_cnt++;
    chk_cnt++; if (rx_words[rx0 % 16] !== 32'hA5A50001) $display("FAIL stable_rx_word: got %h expected a5a50001", rx_words[rx0 % 16]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, rx0, dn0;
    rx0 = rx_cnt; dn0 = done_cnt;
    s_valid = 1'b1; s_data = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_req = 1'b0;
    chk_cnt++; if (s_ready !== 1'b1) $display("FAIL mid_rst_s_ready: got %b expected 1", s_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (tx_req !== 1'b0) $display("FAIL mid_rst_tx_req: got %b expected 0", tx_req); else pass_cnt++;
    chk_cnt++; if (tx_data !== '0) $display("FAIL mid_rst_tx_data: got %h expected 0", tx_data); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk_cnt++; if (done_cnt !== dn0) $display("FAIL mid_rst_no_done: got %0d pulses expected 0", done_cnt - dn0); else pass_cnt++;
    chk_cnt++; if (rx_cnt !== rx0) $display("FAIL mid_rst_no_capture: got %0d words expected 0", rx_cnt - rx0); else pass_cnt++;
    s_valid = 1'b1; s_data = 32'h00000005;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    exp_req = ~exp_req;
    chk_cnt++; if (tx_req !== 1'b1) $display("FAIL mid_rst_next_req: got %b expected 1", tx_req); else pass_cnt++;
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk_cnt++; if (done !== 1'b1) $display("FAIL mid_rst_next_done: got %b expected 1", done); else pass_cnt++;
    chk_cnt++; if (rx_words[rx0 % 16] !== 32'h00000005) $display("FAIL mid_rst_next_word: got %h expected 00000005", rx_words[rx0 % 16]); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_slow_dest();
    int n;
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (s_ready2 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      sent2[i] = $urandom;
      s_data2  = sent2[i];
      s_valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_valid2 = 1'b0;
      s_data2  = $urandom;
      n = 0;
      while (done2 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      chk_cnt++;
      if (done2 !== 1'b1 || lat2 < 3 || lat2 > 4)
        $display("FAIL slow_ack_latency word %0d: got done=%b latency=%0d expected done=1 latency 3..4", i, done2, lat2);
      else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (rx2_cnt !== 100) $display("FAIL slow_rx_count: got %0d expected 100", rx2_cnt); else pass_cnt++;
    chk_cnt++; if (done2_cnt !== 100) $display("FAIL slow_done_pulses: got %0d expected 100", done2_cnt); else pass_cnt++;
    for (int i = 0; i < 100; i++) begin
      chk_cnt++;
      if (rx2_words[i] !== sent2[i]) $display("FAIL slow_rx_order idx %0d: got %h expected %h", i, rx2_words[i], sent2[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_data_stable();
    test_reset_mid();
    test_slow_dest();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
